// File: rtl/fork_fflop_if.sv
// Handshake bundle for the two-way fork: one producer stream in, two consumer streams out.
interface fork_fflop_if #(
    parameter int unsigned Size = 8
);
    logic [Size-1:0] inp;
    logic [1:0]      inp_mask;
    logic            inpValid;
    logic            inpRetry;
    logic [Size-1:0] out_a;
    logic            out_aValid;
    logic            out_aRetry;
    logic [Size-1:0] out_b;
    logic            out_bValid;
    logic            out_bRetry;

    modport master (
        output inp, inp_mask, inpValid, out_aRetry, out_bRetry,
        input  inpRetry, out_a, out_aValid, out_b, out_bValid
    );

    modport slave (
        input  inp, inp_mask, inpValid, out_aRetry, out_bRetry,
        output inpRetry, out_a, out_aValid, out_b, out_bValid
    );
endinterface

// File: rtl/fork_fflop.sv
// Two-way fork: replicates each accepted input into the 2-entry FIFO of every masked branch.
// Input retry is driven only by reset and registered occupancy, cutting the output retry paths.
module fork_fflop #(
    parameter int unsigned Size = 8
) (
    input logic          clk,
    input logic          reset,
    fork_fflop_if.slave  bus
);
    localparam int unsigned NumBr = 2;

    logic [1:0]      r_cnt [NumBr];
    logic [Size-1:0] r_e0  [NumBr];
    logic [Size-1:0] r_e1  [NumBr];

    logic             w_in_retry;
    logic             w_accept;
    logic [NumBr-1:0] w_out_retry;
    logic [NumBr-1:0] w_push;
    logic [NumBr-1:0] w_pop;

    // A full branch stalls the input regardless of mask, keeping retry independent of inp_mask.
    assign w_in_retry  = reset || (r_cnt[0] == 2'd2) || (r_cnt[1] == 2'd2);
    assign w_accept    = bus.inpValid && !w_in_retry;
    assign w_out_retry = {bus.out_bRetry, bus.out_aRetry};
    assign w_push      = w_accept ? bus.inp_mask : 2'b00;

    for (genvar g = 0; g < NumBr; g++) begin : g_br
        assign w_pop[g] = (r_cnt[g] != 2'd0) && !w_out_retry[g];

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt[g] <= 2'd0;
            end else if (w_push[g] && !w_pop[g]) begin
                r_cnt[g] <= r_cnt[g] + 2'd1;
            end else if (w_pop[g] && !w_push[g]) begin
                r_cnt[g] <= r_cnt[g] - 2'd1;
            end
        end

        // Data path is unreset; a push into an empty or simultaneously draining head lands in entry0.
        always_ff @(posedge clk) begin
            if (w_push[g] && ((r_cnt[g] == 2'd0) || w_pop[g])) begin
                r_e0[g] <= bus.inp;
            end else if (w_pop[g]) begin
                r_e0[g] <= r_e1[g];
            end
            if (w_push[g] && !w_pop[g] && (r_cnt[g] == 2'd1)) begin
                r_e1[g] <= bus.inp;
            end
        end
    end

    assign bus.inpRetry   = w_in_retry;
    assign bus.out_a      = r_e0[0];
    assign bus.out_aValid = (r_cnt[0] != 2'd0);
    assign bus.out_b      = r_e0[1];
    assign bus.out_bValid = (r_cnt[1] != 2'd0);
endmodule
